// File: rtl/dual_config_csr_responder_if.sv
// -----------------------------------------------------------------------------
// dual_config_csr_responder_if
// Avalon-MM style register bus between the control-interface initiator and the
// dual-image configuration CSR responder.
//   Addr      : register select (0 = status, 1 = control)
//   Read      : one-cycle read strobe
//   ReadData  : registered read data from the responder
//   Write     : one-cycle write strobe
//   WriteData : write data
// -----------------------------------------------------------------------------
interface dual_config_csr_responder_if;
   logic        Addr;
   logic        Read;
   logic [31:0] ReadData;
   logic        Write;
   logic [31:0] WriteData;

   modport master (
      output Addr,
      output Read,
      output Write,
      output WriteData,
      input  ReadData
   );

   modport slave (
      input  Addr,
      input  Read,
      input  Write,
      input  WriteData,
      output ReadData
   );
endinterface

// File: rtl/dual_config_csr_responder.sv
// -----------------------------------------------------------------------------
// dual_config_csr_responder
// Control/status register pair for dual-image configuration plus the
// reconfiguration-request sequencer started from the control register.
//
// Ports:
//   clk               : system clock, rising edge
//   reset_n           : asynchronous active-low reset
//   bus               : register bus (slave modport)
//   reconfig_req      : one-cycle request pulse, high during ARM
//   config_sel_out    : stored image select (control bit2)
//   sel_overwrite_out : stored image-select override (control bit1)
//   busy              : sequencer not IDLE
//
// Optional build macro: DUAL_CONFIG_CLEAR_ON_READ_EN
//   defined   -> a status read clears WR_BUSY_ERR (a same-edge set wins)
//   undefined -> WR_BUSY_ERR is sticky until reset
//
// Sequencer states:
//   state | meaning
//   IDLE  | waiting for a trigger write, control writes accepted
//   ARM   | one cycle, reconfig_req asserted
//   BUSY  | BUSY_CYCLES cycles, down-counter running
//   DONE  | one cycle, trigger counter incremented
// -----------------------------------------------------------------------------
module dual_config_csr_responder #(
   parameter int BUSY_CYCLES = 16,
   parameter int CNT_W       = 8
) (
   input  logic                        clk,
   input  logic                        reset_n,
   dual_config_csr_responder_if.slave  bus,
   output logic                        reconfig_req,
   output logic                        config_sel_out,
   output logic                        sel_overwrite_out,
   output logic                        busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ARM  = 2'd1;
   localparam logic [1:0] S_BUSY = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [7:0]       BUSY_LOAD = 8'(BUSY_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [1:0]       r_state;
   logic [7:0]       r_cnt;
   logic [CNT_W-1:0] r_trig_cnt;
   logic             r_sel;
   logic             r_sel_ovr;
   logic             r_wr_err;
   logic [31:0]      r_rdata;

   logic             w_idle;
   logic             w_wr_ctrl;
   logic             w_busy_err;
   logic [31:0]      w_status;
   logic [31:0]      w_ctrl;

   assign w_idle     = (r_state == S_IDLE);
   assign w_wr_ctrl  = bus.Write & bus.Addr;
   assign w_busy_err = w_wr_ctrl & ~w_idle;

   assign w_status = {16'b0, r_trig_cnt, 4'b0, r_state, r_wr_err, ~w_idle};
   assign w_ctrl   = {29'b0, r_sel, r_sel_ovr, 1'b0};

   assign busy              = ~w_idle;
   assign reconfig_req      = (r_state == S_ARM);
   assign config_sel_out    = r_sel;
   assign sel_overwrite_out = r_sel_ovr;
   assign bus.ReadData      = r_rdata;

   // Read data captures pre-edge register values, so a simultaneous write
   // is only visible on a later read.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rdata <= '0;
      end else if (bus.Read) begin
         r_rdata <= bus.Addr ? w_ctrl : w_status;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sel     <= 1'b0;
         r_sel_ovr <= 1'b0;
      end else if (w_wr_ctrl && w_idle) begin
         r_sel     <= bus.WriteData[2];
         r_sel_ovr <= bus.WriteData[1];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_err <= 1'b0;
      end else begin
`ifdef DUAL_CONFIG_CLEAR_ON_READ_EN
         // Set has priority over the read-clear on the same edge.
         if (w_busy_err)
            r_wr_err <= 1'b1;
         else if (bus.Read && !bus.Addr)
            r_wr_err <= 1'b0;
`else
         if (w_busy_err)
            r_wr_err <= 1'b1;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_trig_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_wr_ctrl && bus.WriteData[0])
                  r_state <= S_ARM;
            end
            S_ARM: begin
               r_cnt   <= BUSY_LOAD;
               r_state <= S_BUSY;
            end
            S_BUSY: begin
               if (r_cnt == 8'd0)
                  r_state <= S_DONE;
               else
                  r_cnt <= r_cnt - 8'd1;
            end
            S_DONE: begin
               r_trig_cnt <= r_trig_cnt + CNT_ONE;
               r_state    <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dual_config_csr_responder.sv
module tb_dual_config_csr_responder;

   localparam int B = 16;

   logic clk;
   logic reset_n;
   logic reconfig_req, config_sel_out, sel_overwrite_out, busy;

   dual_config_csr_responder_if bus ();

   dual_config_csr_responder #(.BUSY_CYCLES(B), .CNT_W(8)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .bus               (bus),
      .reconfig_req      (reconfig_req),
      .config_sel_out    (config_sel_out),
      .sel_overwrite_out (sel_overwrite_out),
      .busy              (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: the sequence is a timeline of B+2 cycles after a
   // trigger edge (ARM, B x BUSY, DONE); m_remain counts cycles left.
   logic        m_sel, m_ovr, m_err;
   int          m_cnt;
   int          m_remain;
   logic [31:0] m_rdata;

   function automatic int m_phase();
      if (m_remain == 0)     return 0;
      if (m_remain == B + 2) return 1;
      if (m_remain == 1)     return 3;
      return 2;
   endfunction

   function automatic logic [31:0] m_status();
      logic [31:0] s;
      s = 32'(m_cnt % 256) * 256 + 32'(m_phase()) * 4;
      if (m_err)         s = s + 2;
      if (m_remain != 0) s = s + 1;
      return s;
   endfunction

   function automatic logic [31:0] m_ctrl();
      return (m_sel ? 32'd4 : 32'd0) + (m_ovr ? 32'd2 : 32'd0);
   endfunction

   function automatic void model_reset();
      m_sel = 0; m_ovr = 0; m_err = 0; m_cnt = 0; m_remain = 0; m_rdata = 0;
   endfunction

   function automatic void model_edge(input logic r, input logic w, input logic a,
                                      input logic [31:0] wd);
      int nrem;
      if (r) m_rdata = a ? m_ctrl() : m_status();
`ifdef DUAL_CONFIG_CLEAR_ON_READ_EN
      if (r && !a) m_err = 0;
`endif
      nrem = m_remain;
      if (m_remain != 0) begin
         if (m_remain == 1) m_cnt = (m_cnt + 1) % 256;
         nrem = m_remain - 1;
      end
      if (w && a) begin
         if (m_remain == 0) begin
            m_sel = wd[2];
            m_ovr = wd[1];
            if (wd[0]) nrem = B + 2;
         end else begin
            m_err = 1;
         end
      end
      m_remain = nrem;
   endfunction

   // One bus cycle: inputs applied at the falling edge, outputs are sampled
   // at the following falling edge.
   task automatic step(input logic r, input logic w, input logic a, input logic [31:0] wd);
      bus.Read = r; bus.Write = w; bus.Addr = a; bus.WriteData = wd;
      model_edge(r, w, a, wd);
      @(posedge clk);
      @(negedge clk);
      bus.Read = 0; bus.Write = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 0;
      model_reset();
      repeat (2) @(negedge clk);
      reset_n = 1;
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while (busy && k < 100) begin
         step(0, 0, 0, 32'h0);
         k++;
      end
      n_tests++;
      if (busy) begin
         n_fail++;
         $display("FAIL %s: busy still %0b after 100 cycles, expected 0", name, busy);
      end
   endtask

   task automatic test_reset();
      reset_n = 0;
      bus.Read = 0; bus.Write = 0; bus.Addr = 0; bus.WriteData = 0;
      model_reset();
      repeat (3) @(negedge clk);
      n_tests++;
      if ({busy, reconfig_req, config_sel_out, sel_overwrite_out} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b expected 0000",
                  {busy, reconfig_req, config_sel_out, sel_overwrite_out});
      end
      n_tests++;
      if (bus.ReadData !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_rdata: got %h expected 0", bus.ReadData);
      end
      reset_n = 1;
      step(1, 0, 0, 32'h0);
      n_tests++;
      if (bus.ReadData !== 32'h0 || m_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_status_read: got %h model %h expected 0", bus.ReadData, m_rdata);
      end
      n_tests++;
      if (busy !== 1'b0 || reconfig_req !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy: busy %b req %b expected 0 0", busy, reconfig_req);
      end
   endtask

   task automatic test_ctrl_write();
      step(0, 1, 1, 32'h6);
      n_tests++;
      if ({config_sel_out, sel_overwrite_out, reconfig_req, busy} !== 4'b1100) begin
         n_fail++;
         $display("FAIL ctrl_write_outputs: got %b expected 1100",
                  {config_sel_out, sel_overwrite_out, reconfig_req, busy});
      end
      step(1, 0, 1, 32'h0);
      n_tests++;
      if (bus.ReadData !== 32'h6) begin
         n_fail++;
         $display("FAIL ctrl_readback: got %h expected 00000006", bus.ReadData);
      end
      idle(2);
      n_tests++;
      if (bus.ReadData !== 32'h6) begin
         n_fail++;
         $display("FAIL rdata_hold: got %h expected 00000006", bus.ReadData);
      end
   endtask

   task automatic test_trigger();
      int n_req, n_busy;
      n_req = 0; n_busy = 0;
      step(0, 1, 1, 32'h1);
      for (int i = 0; i < 60 && (busy || i == 0); i++) begin
         if (reconfig_req) n_req++;
         if (busy) n_busy++;
         step(0, 0, 0, 32'h0);
      end
      n_tests++;
      if (n_req != 1) begin
         n_fail++;
         $display("FAIL trigger_req_len: got %0d cycles expected 1", n_req);
      end
      n_tests++;
      if (n_busy != B + 2) begin
         n_fail++;
         $display("FAIL trigger_busy_len: got %0d cycles expected %0d", n_busy, B + 2);
      end
      step(1, 0, 0, 32'h0);
      n_tests++;
      if (bus.ReadData !== 32'h0000_0100 || m_rdata !== 32'h0000_0100) begin
         n_fail++;
         $display("FAIL trigger_status: got %h model %h expected 00000100", bus.ReadData, m_rdata);
      end
   endtask

   task automatic test_busy_write();
      logic [31:0] e1;
      step(0, 1, 1, 32'h7);
      idle(5);
      step(0, 1, 1, 32'h5);
      n_tests++;
      if ({config_sel_out, sel_overwrite_out} !== 2'b11) begin
         n_fail++;
         $display("FAIL busy_write_sel: got %b expected 11", {config_sel_out, sel_overwrite_out});
      end
      wait_idle("busy_write_wait");
      step(1, 0, 0, 32'h0);
      n_tests++;
      if (bus.ReadData !== 32'h0000_0202 || m_rdata !== 32'h0000_0202) begin
         n_fail++;
         $display("FAIL busy_err_read1: got %h model %h expected 00000202", bus.ReadData, m_rdata);
      end
`ifdef DUAL_CONFIG_CLEAR_ON_READ_EN
      e1 = 32'h0000_0200;
`else
      e1 = 32'h0000_0202;
`endif
      step(1, 0, 0, 32'h0);
      n_tests++;
      if (bus.ReadData !== e1 || m_rdata !== e1) begin
         n_fail++;
         $display("FAIL busy_err_read2: got %h model %h expected %h", bus.ReadData, m_rdata, e1);
      end
   endtask

   task automatic test_rw_same();
      do_reset();
      step(0, 1, 1, 32'h2);
      step(1, 1, 1, 32'h4);
      n_tests++;
      if (bus.ReadData !== 32'h2 || config_sel_out !== 1'b1 || sel_overwrite_out !== 1'b0) begin
         n_fail++;
         $display("FAIL rw_same: rdata %h sel %b ovr %b expected 00000002 1 0",
                  bus.ReadData, config_sel_out, sel_overwrite_out);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int t = 0; t < 256; t++) begin
         step(0, 1, 1, 32'h1);
         wait_idle("wrap_wait");
      end
      step(1, 0, 0, 32'h0);
      n_tests++;
      if (bus.ReadData !== 32'h0) begin
         n_fail++;
         $display("FAIL wrap_256: got %h expected 00000000", bus.ReadData);
      end
      step(0, 1, 1, 32'h1);
      wait_idle("wrap_wait");
      step(1, 0, 0, 32'h0);
      n_tests++;
      if (bus.ReadData[15:8] !== 8'h01 || bus.ReadData !== m_rdata) begin
         n_fail++;
         $display("FAIL wrap_257: got %h model %h expected cnt 01", bus.ReadData, m_rdata);
      end
   endtask

   task automatic test_reset_mid();
      step(0, 1, 1, 32'h7);
      idle(5);
      step(1, 0, 0, 32'h0);
      #2;
      reset_n = 0;
      model_reset();
      #1;
      n_tests++;
      if ({busy, reconfig_req, config_sel_out, sel_overwrite_out} !== 4'b0000 ||
          bus.ReadData !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: got %b rdata %h expected 0000 0",
                  {busy, reconfig_req, config_sel_out, sel_overwrite_out}, bus.ReadData);
      end
      @(negedge clk);
      reset_n = 1;
      step(1, 0, 0, 32'h0);
      n_tests++;
      if (bus.ReadData !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mid_status: got %h expected 0", bus.ReadData);
      end
   endtask

   task automatic test_random();
      logic r, w, a;
      logic [31:0] wd;
      for (int i = 0; i < 400; i++) begin
         r  = 1'($urandom_range(0, 1));
         w  = ($urandom_range(0, 3) == 0);
         a  = 1'($urandom_range(0, 1));
         wd = $urandom;
         if ($urandom_range(0, 3) != 0) wd[0] = 1'b0;
         step(r, w, a, wd);
         n_tests++;
         if (bus.ReadData !== m_rdata || busy !== (m_remain != 0) ||
             reconfig_req !== (m_remain == B + 2) ||
             config_sel_out !== m_sel || sel_overwrite_out !== m_ovr) begin
            n_fail++;
            $display("FAIL random[%0d]: rdata %h busy %b req %b sel %b ovr %b; model %h %b %b %b %b",
                     i, bus.ReadData, busy, reconfig_req, config_sel_out, sel_overwrite_out,
                     m_rdata, m_remain != 0, m_remain == B + 2, m_sel, m_ovr);
         end
      end
   endtask

   initial begin
      test_reset();
      test_ctrl_write();
      test_trigger();
      test_busy_write();
      test_rw_same();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $fatal(1, "timeout");
   end

endmodule
